// File: rtl/sync_gen_pkg.sv
// ---------------------------------------------------------------------------
// sync_gen_pkg
//   Shared definitions for the sync_gen slice: FSM state encodings and the
//   smallest pulse spacing the generator will run at.
//   No ports; import with "import sync_gen_pkg::*;".
// ---------------------------------------------------------------------------
package sync_gen_pkg;

   // State encodings are fixed values so that downstream debug tooling and
   // older logic analysers that decode the raw state bits keep working.
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ARMED = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;

   // A spacing of 0 or 1 cycles cannot produce distinct pulses, so anything
   // below this is promoted to it when the run starts.
   localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/pulse_stretch.sv
// ---------------------------------------------------------------------------
// pulse_stretch
//   Load/extend counter: a start request makes 'out' high for the next
//   PULSE_WIDTH enabled cycles. A new start while a pulse is running reloads
//   the counter, so back-to-back starts give one continuous high level.
//
//   Ports:
//     clk   in   system clock, rising edge
//     rst   in   asynchronous active-low reset
//     en    in   clock enable; counter and output hold when low
//     start in   begin (or restart) a pulse
//     out   out  registered stretched pulse
// ---------------------------------------------------------------------------
module pulse_stretch #(
   parameter int PULSE_WIDTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic start,
   output logic out
);

   localparam int CW = $clog2(PULSE_WIDTH + 1);

   logic [CW-1:0] remaining;

   // 'remaining' counts the high cycles still owed including the current one,
   // so the output drops on the edge where only the last one has been served.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         remaining <= '0;
         out       <= 1'b0;
      end else if (en) begin
         if (start) begin
            remaining <= CW'(PULSE_WIDTH);
            out       <= 1'b1;
         end else if (remaining > CW'(1)) begin
            remaining <= remaining - 1'b1;
            out       <= 1'b1;
         end else begin
            remaining <= '0;
            out       <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sync_gen.sv
// ---------------------------------------------------------------------------
// sync_gen
//   Periodic sync-pulse generator. After an arm request it waits for the next
//   rising edge of sync_in, then emits a stretched pulse immediately and every
//   period_q enabled cycles afterwards, where period_q is 'period' (min 2)
//   captured when the run starts.
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   asynchronous active-low reset
//     en         in   clock enable; all state holds when low
//     arm        in   single-cycle arm request (also stops a run)
//     sync_in    in   external sync, already synchronised to clk
//     period     in   pulse spacing in enabled cycles
//     sync_out   out  generated sync pulse (registered)
//     armed      out  high while waiting for sync_in (registered)
//     running    out  high while generating pulses (registered)
//     sync_count out  pulses emitted, wraps (registered)
// ---------------------------------------------------------------------------
module sync_gen
   import sync_gen_pkg::*;
#(
   parameter     ARCHITECTURE = "BEHAVIORAL",
   parameter int PERIOD_WIDTH = 16,
   parameter int PULSE_WIDTH  = 1,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    arm,
   input  logic                    sync_in,
   input  logic [PERIOD_WIDTH-1:0] period,
   output logic                    sync_out,
   output logic                    armed,
   output logic                    running,
   output logic [COUNT_WIDTH-1:0]  sync_count
);

   if (ARCHITECTURE == "BEHAVIORAL") begin : g_behavioral

      logic [1:0]              state;
      logic [1:0]              next_state;
      logic                    sync_prev;
      logic [PERIOD_WIDTH-1:0] phase;
      logic [PERIOD_WIDTH-1:0] period_q;
      logic [PERIOD_WIDTH-1:0] period_clamped;
      logic [COUNT_WIDTH-1:0]  count;
      logic                    armed_q;
      logic                    running_q;
      logic                    rise;
      logic                    wrap;
      logic                    pulse_start;

      // The edge history only advances on enabled cycles, so an edge that
      // arrives while en is low is still seen once en returns.
      assign rise = sync_in & ~sync_prev;

      assign period_clamped = (period < PERIOD_WIDTH'(MIN_PERIOD)) ?
                              PERIOD_WIDTH'(MIN_PERIOD) : period;

      assign wrap = (state == RUN) && (phase == period_q - 1'b1);

      // A pulse starts on the aligning edge, or on a wrap unless an arm
      // request in the same cycle is pulling the run back to ARMED.
      assign pulse_start = en & (((state == ARMED) & rise) | (wrap & ~arm));

      // Next-state decode; arm in ARMED is deliberately ignored so that a
      // repeated request does not disturb the wait for sync_in.
      always_comb begin
         next_state = state;
         unique case (state)
            IDLE:    if (arm)  next_state = ARMED;
            ARMED:   if (rise) next_state = RUN;
            RUN:     if (arm)  next_state = ARMED;
            default:           next_state = IDLE;
         endcase
      end

      // FSM, phase counter, latched period and the status flags. The flags
      // are registered from next_state so they line up with 'state'.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state     <= IDLE;
            sync_prev <= 1'b0;
            phase     <= '0;
            period_q  <= '0;
            armed_q   <= 1'b0;
            running_q <= 1'b0;
         end else if (en) begin
            sync_prev <= sync_in;
            state     <= next_state;
            armed_q   <= (next_state == ARMED);
            running_q <= (next_state == RUN);
            if ((state == ARMED) && rise) begin
               phase    <= '0;
               period_q <= period_clamped;
            end else if ((state == RUN) && !arm) begin
               if (wrap) begin
                  phase <= '0;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
         end
      end

      // Pulse counter steps on the same edge that raises sync_out.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            count <= '0;
         end else if (pulse_start) begin
            count <= count + 1'b1;
         end
      end

      pulse_stretch #(
         .PULSE_WIDTH (PULSE_WIDTH)
      ) u_stretch (
         .clk   (clk),
         .rst   (rst),
         .en    (en),
         .start (pulse_start),
         .out   (sync_out)
      );

      assign armed      = armed_q;
      assign running    = running_q;
      assign sync_count = count;

   end else begin : g_vendor

      // VIRTEX5 / VIRTEX6 primitive versions are not provided; outputs stay
      // inactive so a wrong selection is obvious rather than floating.
      assign sync_out   = 1'b0;
      assign armed      = 1'b0;
      assign running    = 1'b0;
      assign sync_count = '0;

   end

endmodule

// File: tb/tb_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_sync_gen
//   Self-checking bench for sync_gen. Three instances with pulse widths 1, 6
//   and 3 share one stimulus stream and are compared every cycle against a
//   schedule-based reference model (absolute pulse times, not a phase
//   counter).
// ---------------------------------------------------------------------------
module tb_sync_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        arm = 1'b0;
   logic        sync_in = 1'b0;
   logic [15:0] period = 16'd8;

   logic        so_o  [3];
   logic        arm_o [3];
   logic        run_o [3];
   logic [15:0] cnt_o [3];

   int checks = 0;
   int fails  = 0;

   // Reference model state, one slot per instance.
   int          m_mode     [3];
   int          m_pq       [3];
   int          m_next     [3];
   int          m_high_end [3];
   logic [15:0] m_cnt      [3];
   logic        m_out      [3];
   logic        m_prev;
   int          m_e;

   always #5 clk = ~clk;

   sync_gen #(.PULSE_WIDTH(1)) dut_w1 (
      .clk(clk), .rst(rst), .en(en), .arm(arm), .sync_in(sync_in),
      .period(period), .sync_out(so_o[0]), .armed(arm_o[0]),
      .running(run_o[0]), .sync_count(cnt_o[0]));

   sync_gen #(.PULSE_WIDTH(6)) dut_w6 (
      .clk(clk), .rst(rst), .en(en), .arm(arm), .sync_in(sync_in),
      .period(period), .sync_out(so_o[1]), .armed(arm_o[1]),
      .running(run_o[1]), .sync_count(cnt_o[1]));

   sync_gen #(.PULSE_WIDTH(3)) dut_w3 (
      .clk(clk), .rst(rst), .en(en), .arm(arm), .sync_in(sync_in),
      .period(period), .sync_out(so_o[2]), .armed(arm_o[2]),
      .running(run_o[2]), .sync_count(cnt_o[2]));

   function automatic int pw_of(input int i);
      case (i)
         0:       return 1;
         1:       return 6;
         default: return 3;
      endcase
   endfunction

   // Puts the model in its reset state: idle, no pulse owed, no history.
   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_mode[i]     = 0;
         m_pq[i]       = 2;
         m_next[i]     = 0;
         m_high_end[i] = -1;
         m_cnt[i]      = 16'd0;
         m_out[i]      = 1'b0;
      end
      m_prev = 1'b0;
      m_e    = 0;
   endtask

   // One clock edge of the model. m_e numbers enabled edges; a pulse started
   // on edge s keeps sync_out high after edges s .. s+PW-1, and during a run
   // the next pulse is due on a fixed absolute edge number.
   task automatic model_step();
      logic rise;
      if (!rst) begin
         model_reset();
         return;
      end
      if (!en) return;
      rise   = sync_in && !m_prev;
      m_prev = sync_in;
      for (int i = 0; i < 3; i++) begin
         case (m_mode[i])
            0: if (arm) m_mode[i] = 1;
            1: if (rise) begin
                  m_mode[i]     = 2;
                  m_pq[i]       = (period < 16'd2) ? 2 : int'(period);
                  m_cnt[i]      = m_cnt[i] + 16'd1;
                  m_high_end[i] = m_e + pw_of(i) - 1;
                  m_next[i]     = m_e + m_pq[i];
               end
            default: if (arm) begin
                  m_mode[i] = 1;
               end else if (m_e == m_next[i]) begin
                  m_cnt[i]      = m_cnt[i] + 16'd1;
                  m_high_end[i] = m_e + pw_of(i) - 1;
                  m_next[i]     = m_e + m_pq[i];
               end
         endcase
         m_out[i] = (m_e <= m_high_end[i]);
      end
      m_e++;
   endtask

   task automatic chk(input string tag, input int inst,
                      input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("[TB] FAIL %s[w%0d] observed=%0h expected=%0h at %0t",
                tag, pw_of(inst), obs, expv, $time);
      end
   endtask

   // Compares every output of every instance against the model.
   task automatic check_output();
      for (int i = 0; i < 3; i++) begin
         chk("sync_out",   i, {31'b0, so_o[i]},  {31'b0, m_out[i]});
         chk("armed",      i, {31'b0, arm_o[i]}, {31'b0, (m_mode[i] == 1)});
         chk("running",    i, {31'b0, run_o[i]}, {31'b0, (m_mode[i] == 2)});
         chk("sync_count", i, {16'b0, cnt_o[i]}, {16'b0, m_cnt[i]});
      end
   endtask

   // Drives one cycle of inputs on the falling edge, advances the model on
   // the rising edge and checks just after it.
   task automatic apply_stimulus(input logic a, input logic s, input logic e);
      @(negedge clk);
      arm     = a;
      sync_in = s;
      en      = e;
      @(posedge clk);
      model_step();
      #1;
      check_output();
   endtask

   task automatic idle_cycles(input int n, input logic s);
      for (int k = 0; k < n; k++) apply_stimulus(1'b0, s, 1'b1);
   endtask

   // Arms the generators (from IDLE or RUN) and aligns them with a fresh
   // sync_in edge, picking up the current 'period'.
   task automatic arm_and_align();
      apply_stimulus(1'b1, 1'b0, 1'b1);
      idle_cycles(2, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      int guard;
      model_reset();

      $display("[TB] reset with random inputs");
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         arm     = 1'($urandom);
         sync_in = 1'($urandom);
         en      = 1'($urandom);
         period  = 16'($urandom);
         @(posedge clk);
         model_step();
         #1;
         check_output();
      end
      @(negedge clk);
      rst    = 1'b1;
      period = 16'd8;
      for (int k = 0; k < 5; k++) apply_stimulus(1'b0, 1'($urandom), 1'b1);

      $display("[TB] basic run, period 8");
      idle_cycles(4, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b1);
      idle_cycles(9, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      idle_cycles(16, 1'b1);
      chk("basic_count", 0, {16'b0, cnt_o[0]}, 32'd3);
      chk("basic_count", 1, {16'b0, cnt_o[1]}, 32'd3);
      idle_cycles(3, 1'b1);

      $display("[TB] period clamp and continuous stretch");
      period = 16'd1;
      arm_and_align();
      idle_cycles(10, 1'b1);
      period = 16'd0;
      idle_cycles(3, 1'b1);
      period = 16'd4;
      arm_and_align();
      idle_cycles(20, 1'b1);

      $display("[TB] enable gating, period 5");
      period = 16'd5;
      arm_and_align();
      idle_cycles(6, 1'b1);
      for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 1'b1, 1'b0);
      idle_cycles(12, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 1'b1, 1'b0);
      idle_cycles(8, 1'b1);

      $display("[TB] arm colliding with a wrap");
      guard = 0;
      while (m_next[0] != m_e && guard < 40) begin
         apply_stimulus(1'b0, 1'b1, 1'b1);
         guard++;
      end
      chk("wrap_reached", 0, guard, (guard < 40) ? guard : 0);
      apply_stimulus(1'b1, 1'b1, 1'b1);
      chk("collide_armed", 0, {31'b0, arm_o[0]}, 32'd1);
      idle_cycles(3, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      idle_cycles(12, 1'b1);

      $display("[TB] reset during second pulse");
      period = 16'd8;
      arm_and_align();
      guard = 0;
      while (m_cnt[2] != 16'd2 && guard < 40) begin
         apply_stimulus(1'b0, 1'b1, 1'b1);
         guard++;
      end
      chk("second_pulse", 2, {31'b0, so_o[2]}, 32'd1);
      #1;
      rst = 1'b0;
      #1;
      model_reset();
      check_output();
      for (int k = 0; k < 2; k++) apply_stimulus(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 10; k++) apply_stimulus(1'b0, k[0], 1'b1);
      arm_and_align();
      idle_cycles(10, 1'b1);

      $display("[TB] randomized traffic");
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 15) == 0) period = 16'($urandom_range(0, 12));
         apply_stimulus(($urandom_range(0, 29) == 0),
                        1'($urandom),
                        ($urandom_range(0, 4) != 0));
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
